frame_dump_ctrl: RTL and testbench
==================================

Name: frame_dump_ctrl

Overview:
Sequencer that streams one complete downsampled frame out of the downsample read port to the debug UART. On a start request it sends a fixed 4-byte header, then every pixel in raster order. Each byte write is paced by the UART busy flag plus an idle holdoff. It replaces ad-hoc dump logic in board tops and sits in the system-clock domain, between the downsample read side and the uart transmitter.

Parameters:
WIDTH, 40, pixels per row (1..255)
HEIGHT, 30, rows per frame (1..255)
XBITS, 6, width of read_x; must satisfy 2^XBITS >= WIDTH
YBITS, 5, width of read_y; must satisfy 2^YBITS >= HEIGHT
HOLDOFF_BITS, 13, UART idle holdoff counter width; ready after (2^HOLDOFF_BITS)-1 idle cycles
READ_LATENCY, 1, cycles from a read_x/read_y register update to read_q valid (1..3)
HEADER_EN, 1, 1 = send header bytes A5 5A WIDTH HEIGHT before pixels; 0 = pixels only

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  dump request; rising edge detected internally
abort  in  1  level; cancels a dump in progress
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion
read_x  out  XBITS  pixel column address, registered
read_y  out  YBITS  pixel row address, registered
read_q  in  8  pixel data from the buffer, valid READ_LATENCY cycles after an address change
uart_busy  in  1  transmitter busy
uart_write  out  1  one-cycle write strobe
uart_data  out  8  byte to send; stable while uart_write is high

Behaviour:
- Reset values: busy=0, done=0, uart_write=0, uart_data=0, read_x=0, read_y=0, state=IDLE, holdoff=0, start edge register=0.
- Start edge: start_q is start delayed one cycle. The edge is start && !start_q. A start that stays high never retriggers a dump.
- Holdoff counter:
  - Cleared to 0 when uart_busy or uart_write is high.
  - Otherwise increments, saturating at all-ones.
  - tx_ready = (holdoff all-ones) && !uart_busy && !uart_write.
- States: IDLE, HDR, FETCH, SEND, DRAIN.
- IDLE:
  - On a start edge with abort low: read_x=0, read_y=0, byte index=0, busy=1.
  - Next state is HDR if HEADER_EN, else FETCH.
- HDR:
  - When tx_ready: uart_data gets header[idx] (A5, 5A, WIDTH[7:0], HEIGHT[7:0] for idx 0..3) and uart_write=1 for that cycle.
  - After the 4th byte, go to FETCH.
- FETCH:
  - Waits READ_LATENCY cycles with the address held stable, then latches read_q into uart_data.
  - Next state is SEND.
- SEND:
  - When tx_ready: uart_write=1 for one cycle.
  - If x == WIDTH-1 and y == HEIGHT-1: go to DRAIN.
  - Else if x == WIDTH-1: x=0, y=y+1, go to FETCH.
  - Else: x=x+1, go to FETCH.
- DRAIN:
  - Waits for tx_ready, meaning the last byte is fully out plus holdoff.
  - Then done=1 for one cycle, busy=0, state=IDLE.
  - read_x/read_y keep their last values.
- Abort, in any non-IDLE state:
  - Next state is IDLE, busy=0, no done pulse.
  - uart_write is forced 0 in every cycle where abort is high.
- Start edge and abort in the same IDLE cycle: abort wins and no dump starts. A start edge while busy is ignored.
- Byte count per dump = 4*HEADER_EN + WIDTH*HEIGHT. No wrap: the address never exceeds (WIDTH-1, HEIGHT-1).
- uart_write never asserts on two consecutive cycles. Minimum spacing between strobes = 1 + UART busy time + (2^HOLDOFF_BITS - 1).
- Reset mid-dump: all registers return to reset values on the next edge.

Test Plan:
- Bench settings for all scenarios: WIDTH=3, HEIGHT=2, HOLDOFF_BITS=2. The UART model raises uart_busy the cycle after uart_write for 5 cycles. The buffer model returns read_q = {y[3:0], x[3:0]} with latency 1.
- Reset: assert reset for 3 cycles -> busy=0, done=0, uart_write=0, uart_data=00, read_x=0, read_y=0; holding start high through reset release starts no dump.
- Full dump: pulse start -> exactly 10 strobes carrying A5 5A 03 02 00 01 02 10 11 12; then one done pulse; busy falls in the done cycle.
- Pacing: in the full dump, every gap between strobes is >= 1+5+3 = 9 cycles; uart_write never coincides with uart_busy=1.
- HEADER_EN=0, READ_LATENCY=2, start held high for 50 cycles -> 6 strobes 00 01 02 10 11 12, exactly one done, no second dump.
- Abort after the 6th strobe -> busy=0 next cycle, no further strobes, no done; a fresh start edge then gives a complete 10-byte dump from A5.
- Start edge during busy, and start edge with abort in IDLE -> both ignored; the byte stream and done count are unchanged.

Source files
------------

// File: rtl/frame_dump_ctrl.sv
// -----------------------------------------------------------------------------
// frame_dump_ctrl
//
// Streams one complete downsampled frame from the downsample read port to the
// debug UART. A start request sends an optional 4-byte header
// (A5 5A WIDTH HEIGHT), followed by every pixel in raster order. Each byte write
// is paced by the UART busy flag plus an idle holdoff counter.
//
// Ports:
//   i_clock       system clock, all logic on the rising edge
//   i_reset       synchronous, active-high reset
//   i_start       dump request, rising edge detected internally
//   i_abort       level, cancels a dump in progress
//   o_busy        high from the cycle after an accepted start until back in IDLE
//   o_done        one-cycle pulse on normal completion
//   o_read_x      registered pixel column address
//   o_read_y      registered pixel row address
//   i_read_q      pixel data, valid READ_LATENCY cycles after an address change
//   i_uart_busy   transmitter busy
//   o_uart_write  one-cycle write strobe, never asserted while i_abort is high
//   o_uart_data   byte to send, stable while o_uart_write is high
// -----------------------------------------------------------------------------
module frame_dump_ctrl #(
    parameter int WIDTH        = 40,
    parameter int HEIGHT       = 30,
    parameter int XBITS        = 6,
    parameter int YBITS        = 5,
    parameter int HOLDOFF_BITS = 13,
    parameter int READ_LATENCY = 1,
    parameter int HEADER_EN    = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [XBITS-1:0] o_read_x,
    output logic [YBITS-1:0] o_read_y,
    input  logic [7:0]       i_read_q,
    input  logic             i_uart_busy,
    output logic             o_uart_write,
    output logic [7:0]       o_uart_data
);

    localparam logic [XBITS-1:0] X_LAST = XBITS'(WIDTH - 1);
    localparam logic [YBITS-1:0] Y_LAST = YBITS'(HEIGHT - 1);
    localparam logic [1:0]       LAT    = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_SEND  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                    r_start_q;
    logic                    r_start_armed;
    logic [HOLDOFF_BITS-1:0] r_holdoff;
    logic [1:0]              r_hdr_idx;
    logic [1:0]              r_lat_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_uart_write;
    logic [7:0]              r_uart_data;
    logic [XBITS-1:0]        r_x;
    logic [YBITS-1:0]        r_y;

    logic w_start_edge;
    logic w_tx_ready;
    logic w_last_x;
    logic w_last_pix;
    logic w_accept;
    logic w_hdr_wr;
    logic w_fetch_done;
    logic w_send_wr;
    logic w_finish;
    logic w_abort_run;

    function automatic logic [7:0] f_header_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    f_header_byte = 8'hA5;
            2'd1:    f_header_byte = 8'h5A;
            2'd2:    f_header_byte = 8'(WIDTH);
            default: f_header_byte = 8'(HEIGHT);
        endcase
    endfunction

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_read_x     = r_x;
    assign o_read_y     = r_y;
    assign o_uart_data  = r_uart_data;
    // A strobe already registered is still suppressed in a cycle where abort
    // is high, so the UART never sees a write during an abort.
    assign o_uart_write = r_uart_write && !i_abort;

    // The armed flag requires start to have been seen low since reset, so a
    // start level held through reset release does not look like an edge.
    assign w_start_edge = i_start && !r_start_q && r_start_armed;
    assign w_tx_ready   = (&r_holdoff) && !i_uart_busy && !o_uart_write;
    assign w_last_x     = (r_x == X_LAST);
    assign w_last_pix   = w_last_x && (r_y == Y_LAST);

    // Start edge detection and UART idle holdoff.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_start_q     <= 1'b0;
            r_start_armed <= 1'b0;
            r_holdoff     <= '0;
        end else begin
            r_start_q <= i_start;
            if (!i_start) begin
                r_start_armed <= 1'b1;
            end
            if (i_uart_busy || o_uart_write) begin
                r_holdoff <= '0;
            end else if (!(&r_holdoff)) begin
                r_holdoff <= r_holdoff + HOLDOFF_BITS'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge && !i_abort) begin
                    w_state_nxt = (HEADER_EN != 0) ? S_HDR : S_FETCH;
                end
            end
            S_HDR: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tx_ready && (r_hdr_idx == 2'd3)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_lat_cnt == LAT) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tx_ready) begin
                    w_state_nxt = w_last_pix ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (i_abort || w_tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: per-state action strobes for the datapath.
    always_comb begin
        w_accept     = 1'b0;
        w_hdr_wr     = 1'b0;
        w_fetch_done = 1'b0;
        w_send_wr    = 1'b0;
        w_finish     = 1'b0;
        w_abort_run  = 1'b0;
        case (r_state)
            S_IDLE:  w_accept     = w_start_edge && !i_abort;
            S_HDR:   w_hdr_wr     = w_tx_ready && !i_abort;
            S_FETCH: w_fetch_done = (r_lat_cnt == LAT) && !i_abort;
            S_SEND:  w_send_wr    = w_tx_ready && !i_abort;
            S_DRAIN: w_finish     = w_tx_ready && !i_abort;
            default: ;
        endcase
        if (r_state != S_IDLE) begin
            w_abort_run = i_abort;
        end
    end

    // Datapath: address, header index, read latency wait, UART byte/strobe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_uart_write <= 1'b0;
            r_uart_data  <= 8'h00;
            r_x          <= '0;
            r_y          <= '0;
            r_hdr_idx    <= 2'd0;
            r_lat_cnt    <= 2'd0;
        end else begin
            r_uart_write <= w_hdr_wr || w_send_wr;
            r_done       <= w_finish;

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_finish || w_abort_run) begin
                r_busy <= 1'b0;
            end

            // The wait restarts on every entry to FETCH, which always follows
            // an address update (or the address reset at start).
            if (r_state != S_FETCH) begin
                r_lat_cnt <= 2'd0;
            end else if (r_lat_cnt != LAT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end

            if (w_accept) begin
                r_x       <= '0;
                r_y       <= '0;
                r_hdr_idx <= 2'd0;
            end

            if (w_hdr_wr) begin
                r_uart_data <= f_header_byte(r_hdr_idx);
                r_hdr_idx   <= r_hdr_idx + 2'd1;
            end

            if (w_fetch_done) begin
                r_uart_data <= i_read_q;
            end

            // The final pixel leaves the address where it is.
            if (w_send_wr && !w_last_pix) begin
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= r_y + YBITS'(1);
                end else begin
                    r_x <= r_x + XBITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
module tb_frame_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic reset = 1'b1;

    // ---------------- instance A: header on, read latency 1 ----------------
    logic       a_start = 1'b1;
    logic       a_abort = 1'b0;
    logic       a_busy, a_done, a_wr, a_ubusy;
    logic [1:0] a_x;
    logic [0:0] a_y;
    logic [7:0] a_q, a_data;
    int         a_ucnt = 0;
    logic [7:0] a_pipe [3];

    frame_dump_ctrl #(
        .WIDTH(3), .HEIGHT(2), .XBITS(2), .YBITS(1), .HOLDOFF_BITS(2),
        .READ_LATENCY(1), .HEADER_EN(1)
    ) dut_a (
        .i_clock(clk), .i_reset(reset), .i_start(a_start), .i_abort(a_abort),
        .o_busy(a_busy), .o_done(a_done), .o_read_x(a_x), .o_read_y(a_y),
        .i_read_q(a_q), .i_uart_busy(a_ubusy), .o_uart_write(a_wr),
        .o_uart_data(a_data)
    );

    // ---------------- instance B: no header, read latency 2 ----------------
    logic       b_start = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_busy, b_done, b_wr, b_ubusy;
    logic [1:0] b_x;
    logic [0:0] b_y;
    logic [7:0] b_q, b_data;
    int         b_ucnt = 0;
    logic [7:0] b_pipe [3];

    frame_dump_ctrl #(
        .WIDTH(3), .HEIGHT(2), .XBITS(2), .YBITS(1), .HOLDOFF_BITS(2),
        .READ_LATENCY(2), .HEADER_EN(0)
    ) dut_b (
        .i_clock(clk), .i_reset(reset), .i_start(b_start), .i_abort(b_abort),
        .o_busy(b_busy), .o_done(b_done), .o_read_x(b_x), .o_read_y(b_y),
        .i_read_q(b_q), .i_uart_busy(b_ubusy), .o_uart_write(b_wr),
        .o_uart_data(b_data)
    );

    // UART models: busy for 5 cycles starting the cycle after a write.
    // Buffer models: read_q = {y, x} delayed by the read latency.
    always @(posedge clk) begin
        if (a_wr) a_ucnt <= 5; else if (a_ucnt > 0) a_ucnt <= a_ucnt - 1;
        if (b_wr) b_ucnt <= 5; else if (b_ucnt > 0) b_ucnt <= b_ucnt - 1;
        a_pipe[0] <= {4'(a_y), 4'(a_x)};
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        b_pipe[0] <= {4'(b_y), 4'(b_x)};
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_ubusy = (a_ucnt != 0);
    assign b_ubusy = (b_ucnt != 0);
    assign a_q     = a_pipe[0];
    assign b_q     = b_pipe[1];

    // Monitors sample on the falling edge.
    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    int a_done_cnt = 0, b_done_cnt = 0;
    int a_last = -1, b_last = -1;
    int a_min_gap = 1000000, b_min_gap = 1000000;
    int a_coinc = 0, b_coinc = 0;
    int a_done_busy_bad = 0;
    logic a_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (a_wr) begin
            if (a_last >= 0 && (cyc - a_last) < a_min_gap) a_min_gap = cyc - a_last;
            a_last = cyc;
            a_bytes.push_back(a_data);
            if (a_ubusy) a_coinc++;
        end
        if (a_done) begin
            a_done_cnt++;
            if (a_busy || !a_prev_busy) a_done_busy_bad++;
        end
        a_prev_busy = a_busy;
        if (b_wr) begin
            if (b_last >= 0 && (cyc - b_last) < b_min_gap) b_min_gap = cyc - b_last;
            b_last = cyc;
            b_bytes.push_back(b_data);
            if (b_ubusy) b_coinc++;
        end
        if (b_done) b_done_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_a();
        a_bytes.delete();
        a_last    = -1;
        a_min_gap = 1000000;
    endtask

    task automatic wait_a_done(input int target, input int budget, input string tag);
        int n = 0;
        while (a_done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, a_done_cnt, target);
    endtask

    function automatic logic [31:0] a_byte(input int i);
        return (i < a_bytes.size()) ? {24'h0, a_bytes[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] b_byte(input int i);
        return (i < b_bytes.size()) ? {24'h0, b_bytes[i]} : 32'hDEAD;
    endfunction

    logic [7:0] exp_full [10] = '{8'hA5, 8'h5A, 8'h03, 8'h02, 8'h00,
                                  8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
    logic [7:0] exp_pix  [6]  = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};

    initial begin
        int n;

        // Reset for 3 cycles with A's start held high.
        tick(3);
        chk("rst_busy",  a_busy, 0);
        chk("rst_done",  a_done, 0);
        chk("rst_write", a_wr, 0);
        chk("rst_data",  a_data, 8'h00);
        chk("rst_x",     a_x, 0);
        chk("rst_y",     a_y, 0);
        reset = 1'b0;
        tick(15);
        chk("held_start_busy",    a_busy, 0);
        chk("held_start_strobes", a_bytes.size(), 0);
        chk("held_start_done",    a_done_cnt, 0);
        a_start = 1'b0;
        tick(5);

        // Full dump, with a start edge injected while busy.
        clear_a();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        chk("start_busy", a_busy, 1);
        tick(30);
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_a_done(1, 400, "full_done_seen");
        chk("full_count", a_bytes.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("full_byte%0d", i), a_byte(i), exp_full[i]);
        chk("full_gap_ge9",   (a_min_gap >= 9) ? 1 : 0, 1);
        chk("full_coinc",     a_coinc, 0);
        chk("full_done_busy", a_done_busy_bad, 0);
        chk("last_x", a_x, 2);
        chk("last_y", a_y, 1);
        tick(40);
        chk("full_no_retrig_cnt",  a_bytes.size(), 10);
        chk("full_no_retrig_done", a_done_cnt, 1);

        // Start edge together with abort in IDLE.
        a_start = 1'b1;
        a_abort = 1'b1;
        tick(1);
        a_start = 1'b0;
        a_abort = 1'b0;
        tick(30);
        chk("abort_idle_busy",  a_busy, 0);
        chk("abort_idle_count", a_bytes.size(), 10);
        chk("abort_idle_done",  a_done_cnt, 1);

        // Abort after the 6th strobe.
        clear_a();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        n = 0;
        while (a_bytes.size() < 6 && n < 300) begin
            tick(1);
            n++;
        end
        chk("abort_reach6", a_bytes.size(), 6);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        chk("abort_busy_next", a_busy, 0);
        tick(60);
        chk("abort_count", a_bytes.size(), 6);
        chk("abort_done",  a_done_cnt, 1);
        for (int i = 0; i < 6; i++) chk($sformatf("abort_byte%0d", i), a_byte(i), exp_full[i]);

        // Fresh dump after the abort.
        clear_a();
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_a_done(2, 400, "redo_done_seen");
        chk("redo_count", a_bytes.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("redo_byte%0d", i), a_byte(i), exp_full[i]);
        chk("a_coinc_total", a_coinc, 0);

        // Instance B: start held high 50 cycles.
        b_start = 1'b1;
        tick(50);
        b_start = 1'b0;
        n = 0;
        while (b_done_cnt < 1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("b_done_seen", b_done_cnt, 1);
        tick(40);
        chk("b_count", b_bytes.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("b_byte%0d", i), b_byte(i), exp_pix[i]);
        chk("b_done_once", b_done_cnt, 1);
        chk("b_gap_ge9",   (b_min_gap >= 9) ? 1 : 0, 1);
        chk("b_coinc",     b_coinc, 0);
        chk("b_idle_busy", b_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
